// File: rtl/ntt_poly_responder_pkg.sv
// rtl/ntt_poly_responder_pkg.sv - shared types and constants for the polynomial responder
package ntt_poly_responder_pkg;

    localparam int COEF_W   = 12;
    localparam int ML_KEM_N = 256;
    localparam int ML_KEM_Q = 3329;
    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 9;

    // Modulus widened to hold an unreduced sum of two coefficients
    localparam logic [COEF_W:0] Q_EXT = (COEF_W+1)'(ML_KEM_Q);

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_LOAD_A,
        CMD_LOAD_B,
        CMD_READ_A,
        CMD_READ_B,
        CMD_ADD
    } poly_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_READ_A,
        S_READ_B,
        S_ADD
    } state_t;

    // Fixed-priority pick of one command; lower-priority pulses are simply dropped
    function automatic poly_cmd_t decode_cmd(input logic la, input logic lb, input logic ra,
                                             input logic rb, input logic ad);
        if (la)      return CMD_LOAD_A;
        else if (lb) return CMD_LOAD_B;
        else if (ra) return CMD_READ_A;
        else if (rb) return CMD_READ_B;
        else if (ad) return CMD_ADD;
        else         return CMD_NONE;
    endfunction

endpackage

// File: rtl/ntt_poly_responder_if.sv
// rtl/ntt_poly_responder_if.sv - serial polynomial port between wrapper and responder
interface ntt_poly_responder_if;
    import ntt_poly_responder_pkg::*;

    logic  load_a_i;
    logic  load_b_i;
    logic  read_a_i;
    logic  read_b_i;
    logic  start_add_i;
    coef_t din_i;
    coef_t dout_o;
    logic  dout_valid_o;
    logic  busy_o;
    logic  done_o;
    logic  cmd_err_o;

    modport master (
        output load_a_i, load_b_i, read_a_i, read_b_i, start_add_i, din_i,
        input  dout_o, dout_valid_o, busy_o, done_o, cmd_err_o
    );

    modport slave (
        input  load_a_i, load_b_i, read_a_i, read_b_i, start_add_i, din_i,
        output dout_o, dout_valid_o, busy_o, done_o, cmd_err_o
    );

endinterface

// File: rtl/ntt_poly_responder_mod_add_q.sv
// rtl/ntt_poly_responder_mod_add_q.sv - combinational (a+b) mod q for reduced operands
module mod_add_q
    import ntt_poly_responder_pkg::*;
(
    input  coef_t a_i,
    input  coef_t b_i,
    output coef_t y_o
);

    logic [COEF_W:0] sum;
    logic [COEF_W:0] sum_sub;

    // Operands are below q, so a single conditional subtraction fully reduces
    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign sum_sub = sum - Q_EXT;
    assign y_o     = (sum >= Q_EXT) ? sum_sub[COEF_W-1:0] : sum[COEF_W-1:0];

endmodule

// File: rtl/ntt_poly_responder.sv
// rtl/ntt_poly_responder.sv - two-bank polynomial load/read/add responder
module ntt_poly_responder
    import ntt_poly_responder_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_n_i,
    ntt_poly_responder_if.slave bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    coef_t            dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;

    coef_t            bank_a [ML_KEM_N];
    coef_t            bank_b [ML_KEM_N];
    logic [ADDR_W-1:0] addr;
    coef_t            rd_a, rd_b, sum;
    coef_t            wdata_a;
    logic             we_a, we_b;
    poly_cmd_t        cmd;

    // Idle prefetches index 0 so a read stream starts the cycle after its pulse
    assign addr = (state_q == S_IDLE) ? '0 : cnt_q[ADDR_W-1:0];
    assign rd_a = bank_a[addr];
    assign rd_b = bank_b[addr];

    mod_add_q u_mod_add (
        .a_i (rd_a),
        .b_i (rd_b),
        .y_o (sum)
    );

    // Next-state, counter, output and bank-write decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = '0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        we_a      = 1'b0;
        we_b      = 1'b0;
        wdata_a   = bus.din_i;
        cnt_inc   = cnt_q + CNT_W'(1);
        cmd       = decode_cmd(bus.load_a_i, bus.load_b_i, bus.read_a_i,
                               bus.read_b_i, bus.start_add_i);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                case (cmd)
                    CMD_LOAD_A: state_d = S_LOAD_A;
                    CMD_LOAD_B: state_d = S_LOAD_B;
                    CMD_ADD:    state_d = S_ADD;
                    CMD_READ_A: begin
                        state_d = S_READ_A;
                        dout_d  = rd_a;
                        valid_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end
                    CMD_READ_B: begin
                        state_d = S_READ_B;
                        dout_d  = rd_b;
                        valid_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            S_LOAD_A, S_LOAD_B, S_ADD: begin
                we_a = (state_q != S_LOAD_B);
                we_b = (state_q == S_LOAD_B);
                if (state_q == S_ADD) begin
                    wdata_a = sum;
                end
                if (cnt_inc[CNT_W-1]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_READ_A, S_READ_B: begin
                if (cnt_q[CNT_W-1]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    dout_d  = (state_q == S_READ_A) ? rd_a : rd_b;
                    valid_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if ((state_q != S_IDLE) && (cmd != CMD_NONE)) begin
            cmd_err_d = 1'b1;
        end
    end

    // Control and output registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Bank A write port: loads and add write-back
    always_ff @(posedge clk_i) begin
        if (we_a) begin
            bank_a[addr] <= wdata_a;
        end
    end

    // Bank B write port: loads only
    always_ff @(posedge clk_i) begin
        if (we_b) begin
            bank_b[addr] <= bus.din_i;
        end
    end

    assign bus.dout_o       = dout_q;
    assign bus.dout_valid_o = valid_q;
    assign bus.busy_o       = (state_q != S_IDLE);
    assign bus.done_o       = done_q;
    assign bus.cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_ntt_poly_responder.sv
// tb/tb_ntt_poly_responder.sv - randomized self-checking bench for ntt_poly_responder
module tb_ntt_poly_responder;

    localparam int N = 256;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    int   ref_a [N];
    int   ref_b [N];
    int   stim  [N];

    ntt_poly_responder_if bus();

    ntt_poly_responder dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in the current idle cycle, ends in the done cycle
    task automatic run_load(input bit sel_b, input int err_at, input bit extra_read_a);
        if (sel_b) bus.load_b_i = 1'b1;
        else       bus.load_a_i = 1'b1;
        if (extra_read_a) bus.read_a_i = 1'b1;
        tick();
        bus.load_a_i = 1'b0;
        bus.load_b_i = 1'b0;
        bus.read_a_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k == 0) chk("load_busy", bus.busy_o, 1);
            chk("load_no_valid", bus.dout_valid_o, 0);
            chk("load_no_done", bus.done_o, 0);
            chk("load_cmd_err", bus.cmd_err_o, (err_at >= 0 && k == err_at + 1) ? 1 : 0);
            bus.din_i = 12'(stim[k]);
            if (k == err_at) bus.read_a_i = 1'b1;
            tick();
            bus.read_a_i = 1'b0;
        end
        bus.din_i = '0;
        chk("load_done", bus.done_o, 1);
        chk("load_idle", bus.busy_o, 0);
        chk("load_err_end", bus.cmd_err_o, 0);
        for (int k = 0; k < N; k++) begin
            if (sel_b) ref_b[k] = stim[k];
            else       ref_a[k] = stim[k];
        end
    endtask

    task automatic run_read(input bit sel_b);
        chk("read_pre_valid", bus.dout_valid_o, 0);
        if (sel_b) bus.read_b_i = 1'b1;
        else       bus.read_a_i = 1'b1;
        tick();
        bus.read_a_i = 1'b0;
        bus.read_b_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("read_valid", bus.dout_valid_o, 1);
            chk("read_data", bus.dout_o, sel_b ? ref_b[k] : ref_a[k]);
            chk("read_no_done", bus.done_o, 0);
            tick();
        end
        chk("read_done", bus.done_o, 1);
        chk("read_end_valid", bus.dout_valid_o, 0);
        chk("read_end_dout", bus.dout_o, 0);
        chk("read_idle", bus.busy_o, 0);
    endtask

    task automatic run_add();
        int cyc;
        bus.start_add_i = 1'b1;
        tick();
        bus.start_add_i = 1'b0;
        cyc = 1;
        while (bus.done_o !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("add_done_latency", (cyc == 257 || cyc == 258) ? 1 : 0, 1);
        chk("add_idle", bus.busy_o, 0);
        for (int k = 0; k < N; k++) ref_a[k] = (ref_a[k] + ref_b[k]) % Q;
    endtask

    initial begin
        int seen_done;
        bus.load_a_i    = 1'b0;
        bus.load_b_i    = 1'b0;
        bus.read_a_i    = 1'b0;
        bus.read_b_i    = 1'b0;
        bus.start_add_i = 1'b0;
        bus.din_i       = '0;
        repeat (3) tick();
        chk("rst_dout", bus.dout_o, 0);
        chk("rst_valid", bus.dout_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.cmd_err_o, 0);
        rst_n = 1'b1;
        tick();

        // Ramp into A, then stream it back
        for (int k = 0; k < N; k++) stim[k] = k;
        run_load(1'b0, -1, 1'b0);
        run_read(1'b0);

        // Boundary sums: 3000+500, 3328+0, 1664+1665
        for (int k = 0; k < N; k++) stim[k] = (k % 3 == 0) ? 3000 : (k % 3 == 1) ? 3328 : 1664;
        run_load(1'b0, -1, 1'b0);
        for (int k = 0; k < N; k++) stim[k] = (k % 3 == 0) ? 500 : (k % 3 == 1) ? 0 : 1665;
        run_load(1'b1, -1, 1'b0);
        run_add();
        run_read(1'b0);

        // Busy command in mid-load, then read B on the done cycle
        for (int k = 0; k < N; k++) stim[k] = $urandom_range(0, Q - 1);
        run_load(1'b1, 100, 1'b0);
        run_read(1'b1);

        // Coinciding load_a and read_a: only the load happens
        for (int k = 0; k < N; k++) stim[k] = $urandom_range(0, Q - 1);
        run_load(1'b0, -1, 1'b1);
        run_read(1'b0);

        // Random operands through the adder, twice to accumulate
        for (int k = 0; k < N; k++) stim[k] = $urandom_range(0, Q - 1);
        run_load(1'b1, -1, 1'b0);
        run_add();
        run_add();
        run_read(1'b0);
        run_read(1'b1);

        // Asynchronous reset while coefficient 40 of a read is on the output
        bus.read_a_i = 1'b1;
        tick();
        bus.read_a_i = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        chk("pre_rst_data", bus.dout_o, ref_a[40]);
        chk("pre_rst_valid", bus.dout_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", bus.dout_o, 0);
        chk("async_rst_valid", bus.dout_valid_o, 0);
        chk("async_rst_busy", bus.busy_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.done_o === 1'b1 || bus.dout_valid_o === 1'b1) seen_done++;
            tick();
        end
        chk("no_done_after_rst", seen_done, 0);
        chk("post_rst_busy", bus.busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
